// File: rtl/alu_pkg.sv
// Shared op-code encodings and controller state type for the arbitrated ALU.
// Used by both the alu datapath and the alu_arb controller.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU datapath; unknown op codes produce zero.
// Shift amount is the low five bits of operand B.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_y
);

    logic [4:0] w_shamt;
    logic       w_lt_s;
    logic       w_lt_u;

    assign w_shamt = i_b[4:0];
    assign w_lt_s  = $signed(i_a) < $signed(i_b);
    assign w_lt_u  = i_a < i_b;

    always_comb begin
        o_y = '0;
        case (i_op)
            OP_ADD:  o_y = i_a + i_b;
            OP_SUB:  o_y = i_a - i_b;
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            OP_SRL:  o_y = i_a >> w_shamt;
            OP_SLL:  o_y = i_a << w_shamt;
            OP_SRA:  o_y = $signed(i_a) >>> w_shamt;
            OP_SLT:  o_y = {{(DATA_W-1){1'b0}}, w_lt_s};
            OP_SLTU: o_y = {{(DATA_W-1){1'b0}}, w_lt_u};
            default: o_y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arb.sv
// Two-requester front end sharing one ALU, one transaction in flight at a time.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
//
//   state   | meaning
//   IDLE    | ready to accept; req_ready_o asserted for the granted requester
//   EXEC    | ALU evaluates latched operands; result captured on exit
//   RESP    | result held on rsp_*_o until the owner accepts it
module alu_arb
#(
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [1:0]          req_valid_i,
    output logic [1:0]          req_ready_o,
    input  logic [7:0]          req_op_i,
    input  logic [2*DATA_W-1:0] req_a_i,
    input  logic [2*DATA_W-1:0] req_b_i,
    output logic [1:0]          rsp_valid_o,
    input  logic [1:0]          rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_data_o
);

    import alu_pkg::*;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_owner;
    logic [DATA_W-1:0] r_data;
    logic              w_grant;
    logic              w_accept;
    logic [DATA_W-1:0] w_alu_y;
`ifdef ALU_ARB_RR_EN
    logic              r_ptr;
`endif

    // The pointer only matters when both requesters contend.
    always_comb begin
`ifdef ALU_ARB_RR_EN
        w_grant = (&req_valid_i) ? r_ptr : ~req_valid_i[0];
`else
        w_grant = ~req_valid_i[0];
`endif
    end

    assign w_accept = (r_state == ST_IDLE) && (|req_valid_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready_o = '0;
        rsp_valid_o = '0;
        case (r_state)
            ST_IDLE: begin
                if (|req_valid_i) begin
                    req_ready_o[w_grant] = ~rst_i;
                    w_state_nxt          = ST_EXEC;
                end
            end
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: begin
                rsp_valid_o[r_owner] = 1'b1;
                if (rsp_ready_i[r_owner]) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_owner <= 1'b0;
            r_data  <= '0;
`ifdef ALU_ARB_RR_EN
            r_ptr   <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_op    <= w_grant ? req_op_i[7:4] : req_op_i[3:0];
                r_a     <= w_grant ? req_a_i[2*DATA_W-1:DATA_W] : req_a_i[DATA_W-1:0];
                r_b     <= w_grant ? req_b_i[2*DATA_W-1:DATA_W] : req_b_i[DATA_W-1:0];
                r_owner <= w_grant;
`ifdef ALU_ARB_RR_EN
                r_ptr   <= ~w_grant;
`endif
            end
            if (r_state == ST_EXEC) begin
                r_data <= w_alu_y;
            end
        end
    end

    assign rsp_data_o = r_data;

    alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_op (r_op),
        .i_a  (r_a),
        .i_b  (r_b),
        .o_y  (w_alu_y)
    );

endmodule
